// File: rtl/sat_accumulator.sv
// sat_accumulator: streaming saturating accumulator.
// Accepts a burst of 'len' 16-bit two's-complement samples over a
// valid/ready handshake and adds each one into a running total with a
// 16-bit saturating adder. The adder flags from the last accepted sample
// are kept. The overflow flag is sticky for the whole burst. After the burst
// ends, the total and flags stay visible until the next start.

// Combinational 16-bit saturating adder.
// zr reflects the raw wrapped sum, not the clamped one, so two minimum
// negatives give a clamped 0x8000 result with zr set.
module sat_adder (
   input  logic [15:0] in1,
   input  logic [15:0] in2,
   output logic [15:0] out,
   output logic        zr,
   output logic        neg,
   output logic        ov
);

   logic [15:0] raw;

   // Signed overflow occurs only when both operands have the same sign and
   // the wrapped sum has the other sign. The clamp direction follows the
   // operand sign.
   always_comb begin
      raw = in1 + in2;
      ov  = (in1[15] == in2[15]) && (raw[15] != in1[15]);
      if (ov) begin
         out = in1[15] ? 16'h8000 : 16'h7FFF;
      end else begin
         out = raw;
      end
      zr  = (raw == 16'h0000);
      neg = out[15];
   end

endmodule

module sat_accumulator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [15:0]      in_data,
   output logic             in_ready,
   output logic [15:0]      acc_out,
   output logic             zr,
   output logic             neg,
   output logic             ov,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic             accept;

   logic [15:0]      sum_out;
   logic             sum_zr;
   logic             sum_neg;
   logic             sum_ov;

   // The adder always sees the current total and the presented sample.
   // Its results are used only on a handshake cycle.
   sat_adder adder (
      .in1 (acc_out),
      .in2 (in_data),
      .out (sum_out),
      .zr  (sum_zr),
      .neg (sum_neg),
      .ov  (sum_ov)
   );

   // Status outputs decode straight from registered state. This keeps
   // in_ready independent of in_valid and makes done a clean one-cycle
   // pulse.
   always_comb begin
      in_ready = (state == ACCUM);
      busy     = (state != IDLE);
      done     = (state == DONE);
      accept   = in_valid && in_ready;
   end

   // Burst control and result registers. start is honoured only in IDLE,
   // so a start while busy neither restarts the burst nor reloads len.
   // A zero-length burst clears the result and goes straight to DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         acc_out <= 16'h0000;
         zr      <= 1'b1;
         neg     <= 1'b0;
         ov      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc_out <= 16'h0000;
                  zr      <= 1'b1;
                  neg     <= 1'b0;
                  ov      <= 1'b0;
                  count   <= len;
                  state   <= (len != '0) ? ACCUM : DONE;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_out <= sum_out;
                  zr      <= sum_zr;
                  neg     <= sum_neg;
                  ov      <= ov | sum_ov;
                  count   <= count - CNT_ONE;
                  if (count == CNT_ONE) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sat_accumulator.sv
// Self-checking bench for sat_accumulator.
// The bench pushes the expected burst results onto a scoreboard queue when
// each burst starts. The negedge monitor pops one result each time done
// pulses and compares it with the outputs.
module tb_sat_accumulator;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic [15:0] acc_out;
   logic        zr;
   logic        neg;
   logic        ov;
   logic        busy;
   logic        done;

   typedef struct packed {
      logic [15:0] acc;
      logic        zr;
      logic        neg;
      logic        ov;
   } exp_t;

   typedef struct packed {
      logic [7:0]       len;
      logic [4:0][15:0] s;
      logic [3:0]       gaps;
      exp_t             res;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[10];

   int vecCount    = 0;
   int missCount   = 0;
   int acceptCount = 0;
   logic prevDone  = 1'b0;

   sat_accumulator #(.CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .acc_out  (acc_out),
      .zr       (zr),
      .neg      (neg),
      .ov       (ov),
      .busy     (busy),
      .done     (done)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value and report any mismatch.
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Build one table record.
   function automatic vec_t mk(input logic [7:0] l, input logic [15:0] s0, input logic [15:0] s1,
                               input logic [15:0] s2, input logic [15:0] s3, input logic [15:0] s4,
                               input logic [3:0] g, input logic [15:0] a, input logic z,
                               input logic n, input logic o);
      vec_t v;
      v.len  = l;
      v.s[0] = s0;
      v.s[1] = s1;
      v.s[2] = s2;
      v.s[3] = s3;
      v.s[4] = s4;
      v.gaps = g;
      v.res  = '{acc: a, zr: z, neg: n, ov: o};
      return v;
   endfunction

   // Count real handshakes on the edge, seeing pre-edge in_ready.
   always @(posedge clk) begin
      if (!rst && in_valid && in_ready) acceptCount++;
   end

   // Scoreboard monitor: each done pulse consumes one expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         checkOutput("done_width", {15'd0, prevDone}, 16'd0);
         checkOutput("ready_in_done", {15'd0, in_ready}, 16'd0);
         checkOutput("busy_in_done", {15'd0, busy}, 16'd1);
         if (sb.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL sb_empty: got done=1 expected no pulse");
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("acc_out", acc_out, e.acc);
            checkOutput("zr", {15'd0, zr}, {15'd0, e.zr});
            checkOutput("neg", {15'd0, neg}, {15'd0, e.neg});
            checkOutput("ov", {15'd0, ov}, {15'd0, e.ov});
         end
      end
      prevDone = done;
   end

   // Run one table burst: start, feed samples with optional gaps, then
   // confirm that done lands right after the last handshake.
   task automatic applyStimulus(input vec_t v);
      int waitCycles;
      @(negedge clk);
      start    = 1'b1;
      len      = v.len;
      in_valid = 1'b0;
      sb.push_back(v.res);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < int'(v.len); i++) begin
         in_valid = 1'b0;
         repeat (int'(v.gaps)) @(negedge clk);
         in_valid = 1'b1;
         in_data  = v.s[i];
         @(negedge clk);
      end
      in_valid   = 1'b0;
      waitCycles = 0;
      while (!done && waitCycles < 8) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("done_latency", 16'(waitCycles), 16'd0);
      @(negedge clk);
      checkOutput("busy_after_done", {15'd0, busy}, 16'd0);
   endtask

   // Main stimulus sequence.
   initial begin
      int acceptsBefore;
      logic [6:0] gapPat;

      rst      = 1'b1;
      start    = 1'b0;
      len      = 8'd0;
      in_valid = 1'b0;
      in_data  = 16'h0000;

      vecs[0] = mk(8'd3, 16'h0005, 16'h0003, 16'hFFFE, 16'h0, 16'h0, 4'd0, 16'h0006, 1'b0, 1'b0, 1'b0);
      vecs[1] = mk(8'd2, 16'h7000, 16'h2000, 16'h0, 16'h0, 16'h0, 4'd0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      vecs[2] = mk(8'd1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      vecs[3] = mk(8'd2, 16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 4'd0, 16'h8000, 1'b1, 1'b1, 1'b1);
      vecs[4] = mk(8'd2, 16'h0004, 16'hFFFC, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[5] = mk(8'd2, 16'h8000, 16'hFFFF, 16'h0, 16'h0, 16'h0, 4'd0, 16'h8000, 1'b0, 1'b1, 1'b1);
      vecs[6] = mk(8'd3, 16'h7FFF, 16'h0001, 16'h8001, 16'h0, 16'h0, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b1);
      vecs[7] = mk(8'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[8] = mk(8'd1, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[9] = mk(8'd5, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd2, 16'h5000, 1'b0, 1'b0, 1'b0);

      // Reset values.
      repeat (2) @(negedge clk);
      checkOutput("rst_acc", acc_out, 16'h0000);
      checkOutput("rst_zr", {15'd0, zr}, 16'd1);
      checkOutput("rst_busy", {15'd0, busy}, 16'd0);
      checkOutput("rst_ready", {15'd0, in_ready}, 16'd0);
      rst = 1'b0;

      // Table-driven bursts.
      for (int k = 0; k < 10; k++) applyStimulus(vecs[k]);

      // While IDLE, the last result holds and in_valid is ignored.
      in_valid = 1'b1;
      in_data  = 16'h7FFF;
      repeat (3) @(negedge clk);
      checkOutput("idle_hold_acc", acc_out, 16'h5000);
      checkOutput("idle_hold_ov", {15'd0, ov}, 16'd0);
      in_valid = 1'b0;

      // Gapped handshake with a stray start during ACCUM.
      @(negedge clk);
      start = 1'b1;
      len   = 8'd4;
      sb.push_back('{acc: 16'h0004, zr: 1'b0, neg: 1'b0, ov: 1'b0});
      acceptsBefore = acceptCount;
      @(negedge clk);
      start  = 1'b0;
      gapPat = 7'b1011001;
      for (int c = 0; c < 7; c++) begin
         in_valid = gapPat[c];
         in_data  = 16'h0001;
         start    = (c == 2);
         len      = (c == 2) ? 8'd1 : 8'd4;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      checkOutput("gap_done", {15'd0, done}, 16'd1);
      checkOutput("gap_accepts", 16'(acceptCount - acceptsBefore), 16'd4);
      @(negedge clk);
      checkOutput("gap_idle", {15'd0, busy}, 16'd0);

      // len=0 while in_valid stays high: no sample is consumed.
      in_valid = 1'b1;
      in_data  = 16'h1234;
      acceptsBefore = acceptCount;
      start = 1'b1;
      len   = 8'd0;
      sb.push_back('{acc: 16'h0000, zr: 1'b1, neg: 1'b0, ov: 1'b0});
      @(negedge clk);
      start = 1'b0;
      checkOutput("len0_done", {15'd0, done}, 16'd1);
      @(negedge clk);
      checkOutput("len0_done_off", {15'd0, done}, 16'd0);
      checkOutput("len0_acc", acc_out, 16'h0000);
      checkOutput("len0_accepts", 16'(acceptCount - acceptsBefore), 16'd0);
      in_valid = 1'b0;

      // Hold reset for two cycles in the middle of a burst.
      @(negedge clk);
      start = 1'b1;
      len   = 8'd4;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h0100;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("mid_rst_acc", acc_out, 16'h0000);
      checkOutput("mid_rst_zr", {15'd0, zr}, 16'd1);
      checkOutput("mid_rst_neg", {15'd0, neg}, 16'd0);
      checkOutput("mid_rst_ov", {15'd0, ov}, 16'd0);
      checkOutput("mid_rst_busy", {15'd0, busy}, 16'd0);
      checkOutput("mid_rst_ready", {15'd0, in_ready}, 16'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("post_rst_idle", {15'd0, busy}, 16'd0);

      // A normal burst still works after the reset.
      applyStimulus(vecs[0]);

      checkOutput("sb_drained", 16'(sb.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
